operand_slave: RTL and testbench
================================

OPERAND_SLAVE -- requirements
Module: operand_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries in each storage array (power of two, 2..256).
REQ-002 SHALL have parameter IDX_W, default 4, index width, equal to log2(DEPTH).
REQ-003 SHALL have port PCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port PRESETn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ld_en, input, 1 bit: operand-load strobe.
REQ-006 SHALL have port ld_addr, input, IDX_W bits: operand-load index.
REQ-007 SHALL have port ld_data, input, 16 bits: operand-load data.
REQ-008 SHALL have ports M_arvalid (input, 1), M_Raddr1 (input, 32), M_Raddr2 (input, 32) and M_rready (input, 1): read-channel inputs.
REQ-009 SHALL have ports S_arready (output, 1), S_rvalid (output, 1), S_rresp (output, 2), S_Rdata1 (output, 16) and S_Rdata2 (output, 16): read-channel outputs.
REQ-010 SHALL have ports M_awvalid (input, 1), M_Waddr (input, 32), M_wvalid (input, 1), M_Wdata (input, 32) and M_bready (input, 1): write-channel inputs.
REQ-011 SHALL have ports S_awready (output, 1), S_wready (output, 1), S_bvalid (output, 1) and S_bresp (output, 2): write-channel outputs.
REQ-012 SHALL have port wr_count, output, 8 bits: count of completed write responses.
REQ-013 SHALL have port last_result, output, 32 bits: data of the most recent accepted write.

Function
REQ-014 SHALL hold an operand array of DEPTH x 16 bits and a result array of DEPTH x 32 bits, both in flops.
REQ-015 SHALL write ld_data to operand[ld_addr] at the clock edge when ld_en=1.
REQ-016 SHALL use addr[IDX_W-1:0] as the index and treat addr[31:IDX_W] as out-of-range bits.
REQ-017 SHALL implement a read FSM with states R_IDLE and R_DATA.
REQ-018 SHALL, in R_IDLE, drive S_arready=1 and S_rvalid=0.
REQ-019 SHALL, on M_arvalid=1 in R_IDLE, capture operand[idx1] and operand[idx2] into S_Rdata1/S_Rdata2 using pre-edge array contents, and go to R_DATA.
REQ-020 SHALL, in R_DATA, drive S_rvalid=1 and S_arready=0, holding data and response stable until M_rready=1, then return to R_IDLE.
REQ-021 SHALL assert S_rvalid in the cycle after the address handshake (read latency 1).
REQ-022 SHALL, when ld_en targets a read index at the address-handshake edge, return the old data.
REQ-023 SHALL implement a write FSM with states W_IDLE, W_DATA and W_RESP.
REQ-024 SHALL, in W_IDLE, drive S_awready=1 and, on M_awvalid=1, capture the write index and go to W_DATA.
REQ-025 SHALL, in W_DATA, drive S_wready=1 and, on M_wvalid=1, write M_Wdata to result[idx], load last_result with M_Wdata, and go to W_RESP.
REQ-026 SHALL, in W_RESP, drive S_bvalid=1 until M_bready=1, then increment wr_count (mod 256, wrapping 255->0) and return to W_IDLE.
REQ-027 SHALL ignore M_wvalid asserted together with M_awvalid in W_IDLE; data SHALL be accepted only in W_DATA.
REQ-028 SHALL run the read and write FSMs independently, so simultaneous read and write transactions proceed in parallel.
REQ-029 SHALL drive S_rresp and S_bresp to 2'b00 (OKAY) except as defined in Configuration.

Reset
REQ-030 SHALL, while PRESETn=0, immediately force both FSMs to their idle states (R_IDLE, W_IDLE), including mid-transaction.
REQ-031 SHALL, while PRESETn=0, force S_rvalid=0, S_bvalid=0, S_arready=0, S_awready=0 and S_wready=0.
REQ-032 SHALL, while PRESETn=0, force S_rresp=0, S_bresp=0, S_Rdata1=0, S_Rdata2=0, wr_count=0 and last_result=0.
REQ-033 SHALL clear both storage arrays to 0 during reset.
REQ-034 SHALL drive S_arready=1 and S_awready=1 from the first clock edge after PRESETn deasserts; an in-flight transaction is dropped with no response.

Configuration
REQ-035 SHALL support macro OPSLV_ADDR_ERR_EN.
REQ-036 SHALL, with OPSLV_ADDR_ERR_EN defined: return S_rresp=2'b10 (SLVERR) with data 0 when either read address is out of range.
REQ-037 SHALL, with OPSLV_ADDR_ERR_EN defined: return S_bresp=2'b10 for an out-of-range write, leave result and last_result unchanged, and still increment wr_count.
REQ-038 SHALL, without OPSLV_ADDR_ERR_EN: ignore upper address bits (index wraps) and always return resp 2'b00.

Verification
REQ-039 SHALL cover: load operand[3]=0x0007, operand[5]=0x0009; read Raddr1=3, Raddr2=5 -> S_rvalid one cycle after handshake, Rdata1=0x0007, Rdata2=0x0009, rresp=00.
REQ-040 SHALL cover: write Waddr=2, Wdata=0x0000003F, M_bready delayed 3 cycles -> S_bvalid held for 3 cycles, result[2]=0x3F, last_result=0x3F, wr_count=1.
REQ-041 SHALL cover: M_rready low for 4 cycles -> S_rvalid, Rdata1 and Rdata2 stable; S_arready=0 throughout.
REQ-042 SHALL cover: read addr 0x10 with DEPTH=16 -> with macro rresp=10 and data 0; without macro, data of operand[0] and rresp=00.
REQ-043 SHALL cover: PRESETn low while in W_RESP -> S_bvalid=0 immediately, wr_count=0, arrays 0, S_awready=1 at the first edge after release.
REQ-044 SHALL cover: 256 writes -> wr_count wraps to 0; ld_en to operand[3] at the read-handshake edge -> old value returned.

Source files
------------

// File: rtl/operand_slave.sv
// Operand/result register slave with independent read and write handshake FSMs.
// Optional macro OPSLV_ADDR_ERR_EN turns out-of-range addresses into SLVERR responses.
module operand_slave #(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             PCLK,
   input  logic             PRESETn,
   input  logic             ld_en,
   input  logic [IDX_W-1:0] ld_addr,
   input  logic [15:0]      ld_data,
   input  logic             M_arvalid,
   input  logic [31:0]      M_Raddr1,
   input  logic [31:0]      M_Raddr2,
   input  logic             M_rready,
   output logic             S_arready,
   output logic             S_rvalid,
   output logic [1:0]       S_rresp,
   output logic [15:0]      S_Rdata1,
   output logic [15:0]      S_Rdata2,
   input  logic             M_awvalid,
   input  logic [31:0]      M_Waddr,
   input  logic             M_wvalid,
   input  logic [31:0]      M_Wdata,
   input  logic             M_bready,
   output logic             S_awready,
   output logic             S_wready,
   output logic             S_bvalid,
   output logic [1:0]       S_bresp,
   output logic [7:0]       wr_count,
   output logic [31:0]      last_result
);

   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   r_state_t r_state_reg, r_state_next;
   w_state_t w_state_reg, w_state_next;

   logic [15:0]      operand_mem [DEPTH];
   logic [31:0]      result_mem  [DEPTH];

   logic             ready_reg;
   logic             ar_hs;
   logic             aw_hs;
   logic             w_hs;
   logic             b_hs;
   logic             raddr_err;
   logic             waddr_err;
   logic [15:0]      rdata1_reg;
   logic [15:0]      rdata2_reg;
   logic [1:0]       rresp_reg;
   logic [IDX_W-1:0] widx_reg;
   logic             werr_reg;
   logic [1:0]       bresp_reg;
   logic [7:0]       wr_count_reg;
   logic [IDX_W-1:0] last_idx_reg;

`ifdef OPSLV_ADDR_ERR_EN
   assign raddr_err = (|M_Raddr1[31:IDX_W]) | (|M_Raddr2[31:IDX_W]);
   assign waddr_err = |M_Waddr[31:IDX_W];
`else
   logic unused_addr_bits;
   assign raddr_err        = 1'b0;
   assign waddr_err        = 1'b0;
   assign unused_addr_bits = ^{M_Raddr1[31:IDX_W], M_Raddr2[31:IDX_W], M_Waddr[31:IDX_W]};
`endif

   // Handshake readies stay low until the first edge after reset release.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) ready_reg <= 1'b0;
      else          ready_reg <= 1'b1;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state_reg <= R_IDLE;
         w_state_reg <= W_IDLE;
      end else begin
         r_state_reg <= r_state_next;
         w_state_reg <= w_state_next;
      end
   end

   always_comb begin
      r_state_next = r_state_reg;
      S_arready    = 1'b0;
      S_rvalid     = 1'b0;
      ar_hs        = 1'b0;
      case (r_state_reg)
         R_IDLE: begin
            S_arready = ready_reg;
            if (M_arvalid && ready_reg) begin
               ar_hs        = 1'b1;
               r_state_next = R_DATA;
            end
         end
         R_DATA: begin
            S_rvalid = 1'b1;
            if (M_rready) r_state_next = R_IDLE;
         end
         default: r_state_next = R_IDLE;
      endcase
   end

   always_comb begin
      w_state_next = w_state_reg;
      S_awready    = 1'b0;
      S_wready     = 1'b0;
      S_bvalid     = 1'b0;
      aw_hs        = 1'b0;
      w_hs         = 1'b0;
      b_hs         = 1'b0;
      case (w_state_reg)
         W_IDLE: begin
            S_awready = ready_reg;
            if (M_awvalid && ready_reg) begin
               aw_hs        = 1'b1;
               w_state_next = W_DATA;
            end
         end
         W_DATA: begin
            S_wready = 1'b1;
            if (M_wvalid) begin
               w_hs         = 1'b1;
               w_state_next = W_RESP;
            end
         end
         W_RESP: begin
            S_bvalid = 1'b1;
            if (M_bready) begin
               b_hs         = 1'b1;
               w_state_next = W_IDLE;
            end
         end
         default: w_state_next = W_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) operand_mem[i] <= '0;
      end else if (ld_en) begin
         operand_mem[ld_addr] <= ld_data;
      end
   end

   // Read data is sampled from the pre-edge array, so a same-edge load is not seen.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rdata1_reg <= '0;
         rdata2_reg <= '0;
         rresp_reg  <= 2'b00;
      end else if (ar_hs) begin
         if (raddr_err) begin
            rdata1_reg <= '0;
            rdata2_reg <= '0;
            rresp_reg  <= 2'b10;
         end else begin
            rdata1_reg <= operand_mem[M_Raddr1[IDX_W-1:0]];
            rdata2_reg <= operand_mem[M_Raddr2[IDX_W-1:0]];
            rresp_reg  <= 2'b00;
         end
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         widx_reg     <= '0;
         werr_reg     <= 1'b0;
         bresp_reg    <= 2'b00;
         wr_count_reg <= '0;
         last_idx_reg <= '0;
      end else begin
         if (aw_hs) begin
            widx_reg <= M_Waddr[IDX_W-1:0];
            werr_reg <= waddr_err;
         end
         if (w_hs) begin
            bresp_reg <= werr_reg ? 2'b10 : 2'b00;
            if (!werr_reg) last_idx_reg <= widx_reg;
         end
         if (b_hs) wr_count_reg <= wr_count_reg + 8'd1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int i = 0; i < DEPTH; i++) result_mem[i] <= '0;
      end else if (w_hs && !werr_reg) begin
         result_mem[widx_reg] <= M_Wdata;
      end
   end

   // The entry last written always holds the newest accepted data, so last_result is read from it.
   assign last_result = result_mem[last_idx_reg];
   assign wr_count    = wr_count_reg;
   assign S_Rdata1    = rdata1_reg;
   assign S_Rdata2    = rdata2_reg;
   assign S_rresp     = rresp_reg;
   assign S_bresp     = bresp_reg;

endmodule

// File: tb/tb_operand_slave.sv
// Scoreboard bench for operand_slave: stimulus queues expected responses, a monitor pops them on each handshake.
module tb_operand_slave;
   localparam int DEPTH = 16;
   localparam int IDX_W = 4;

   logic             PCLK = 1'b0;
   logic             PRESETn = 1'b1;
   logic             ld_en = 1'b0;
   logic [IDX_W-1:0] ld_addr = '0;
   logic [15:0]      ld_data = '0;
   logic             M_arvalid = 1'b0;
   logic [31:0]      M_Raddr1 = '0;
   logic [31:0]      M_Raddr2 = '0;
   logic             M_rready = 1'b0;
   logic             S_arready;
   logic             S_rvalid;
   logic [1:0]       S_rresp;
   logic [15:0]      S_Rdata1;
   logic [15:0]      S_Rdata2;
   logic             M_awvalid = 1'b0;
   logic [31:0]      M_Waddr = '0;
   logic             M_wvalid = 1'b0;
   logic [31:0]      M_Wdata = '0;
   logic             M_bready = 1'b0;
   logic             S_awready;
   logic             S_wready;
   logic             S_bvalid;
   logic [1:0]       S_bresp;
   logic [7:0]       wr_count;
   logic [31:0]      last_result;

   operand_slave #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .M_arvalid(M_arvalid), .M_Raddr1(M_Raddr1), .M_Raddr2(M_Raddr2), .M_rready(M_rready),
      .S_arready(S_arready), .S_rvalid(S_rvalid), .S_rresp(S_rresp),
      .S_Rdata1(S_Rdata1), .S_Rdata2(S_Rdata2),
      .M_awvalid(M_awvalid), .M_Waddr(M_Waddr), .M_wvalid(M_wvalid), .M_Wdata(M_Wdata),
      .M_bready(M_bready),
      .S_awready(S_awready), .S_wready(S_wready), .S_bvalid(S_bvalid), .S_bresp(S_bresp),
      .wr_count(wr_count), .last_result(last_result)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] resp;
   } rexp_t;

   typedef struct {
      logic [31:0] resp;
      logic [31:0] last;
   } wexp_t;

   rexp_t rq[$];
   wexp_t wq[$];

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_count = 8'd0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   // Monitor: one pop per response handshake.
   always @(negedge PCLK) begin
      if (PRESETn && S_rvalid && M_rready) begin
         if (rq.size() == 0) begin
            chk("rd_unexpected", 32'(S_rvalid), 0);
         end else begin
            rexp_t e;
            e = rq.pop_front();
            chk("rd_data1", 32'(S_Rdata1), e.d1);
            chk("rd_data2", 32'(S_Rdata2), e.d2);
            chk("rd_resp", 32'(S_rresp), e.resp);
            $display("read  rdata1=0x%04h rdata2=0x%04h rresp=%0d", S_Rdata1, S_Rdata2, S_rresp);
         end
      end
      if (PRESETn && S_bvalid && M_bready) begin
         if (wq.size() == 0) begin
            chk("wr_unexpected", 32'(S_bvalid), 0);
         end else begin
            wexp_t e;
            e = wq.pop_front();
            chk("wr_bresp", 32'(S_bresp), e.resp);
            chk("wr_last_result", last_result, e.last);
            $display("write bresp=%0d last_result=0x%08h", S_bresp, last_result);
         end
      end
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic load(input int idx, input int data);
      ld_en   = 1'b1;
      ld_addr = IDX_W'(idx);
      ld_data = 16'(data);
      tick();
      ld_en   = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a1, input logic [31:0] a2, input int hold,
                          input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] er);
      rq.push_back('{e1, e2, er});
      chk("arready_idle", 32'(S_arready), 1);
      M_arvalid = 1'b1;
      M_Raddr1  = a1;
      M_Raddr2  = a2;
      M_rready  = 1'b0;
      tick();
      M_arvalid = 1'b0;
      ld_en     = 1'b0;
      chk("rvalid_latency", 32'(S_rvalid), 1);
      for (int i = 0; i < hold; i++) begin
         @(negedge PCLK);
         chk("rvalid_hold", 32'(S_rvalid), 1);
         chk("arready_busy", 32'(S_arready), 0);
         chk("rdata1_stable", 32'(S_Rdata1), e1);
         chk("rdata2_stable", 32'(S_Rdata2), e2);
         tick();
      end
      M_rready = 1'b1;
      tick();
      M_rready = 1'b0;
      chk("rvalid_drop", 32'(S_rvalid), 0);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int delay,
                           input bit bogus, input logic [31:0] er, input logic [31:0] elast);
      wq.push_back('{er, elast});
      chk("awready_idle", 32'(S_awready), 1);
      M_awvalid = 1'b1;
      M_Waddr   = addr;
      M_wvalid  = bogus;
      M_Wdata   = ~data;
      M_bready  = 1'b0;
      tick();
      M_awvalid = 1'b0;
      chk("wready_data", 32'(S_wready), 1);
      chk("bvalid_early", 32'(S_bvalid), 0);
      M_wvalid = 1'b1;
      M_Wdata  = data;
      tick();
      M_wvalid = 1'b0;
      for (int i = 0; i < delay; i++) begin
         @(negedge PCLK);
         chk("bvalid_hold", 32'(S_bvalid), 1);
         chk("wready_resp", 32'(S_wready), 0);
         tick();
      end
      M_bready = 1'b1;
      tick();
      M_bready = 1'b0;
      exp_count = exp_count + 8'd1;
      chk("wr_count", 32'(wr_count), 32'(exp_count));
      chk("bvalid_drop", 32'(S_bvalid), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 PRESETn = 1'b0;
      repeat (2) @(negedge PCLK);
      chk("rst_arready", 32'(S_arready), 0);
      chk("rst_awready", 32'(S_awready), 0);
      chk("rst_rvalid", 32'(S_rvalid), 0);
      chk("rst_bvalid", 32'(S_bvalid), 0);
      chk("rst_wr_count", 32'(wr_count), 0);
      chk("rst_last_result", last_result, 0);
      chk("rst_rdata1", 32'(S_Rdata1), 0);
      #2 PRESETn = 1'b1;
      #1 chk("release_arready_pre", 32'(S_arready), 0);
      tick();
      chk("release_arready", 32'(S_arready), 1);
      chk("release_awready", 32'(S_awready), 1);

      // Basic read, delayed-bready write, stalled read
      load(3, 16'h0007);
      load(5, 16'h0009);
      do_read(32'd3, 32'd5, 0, 32'h7, 32'h9, 0);
      do_write(32'd2, 32'h3F, 3, 1'b0, 0, 32'h3F);
      do_read(32'd3, 32'd5, 4, 32'h7, 32'h9, 0);

      // Out-of-range addresses
      load(0, 16'h00AA);
`ifdef OPSLV_ADDR_ERR_EN
      do_read(32'h10, 32'd5, 0, 0, 0, 2);
`else
      do_read(32'h10, 32'd5, 0, 32'hAA, 32'h9, 0);
`endif
      do_write(32'd7, 32'h12345678, 0, 1'b1, 0, 32'h12345678);
`ifdef OPSLV_ADDR_ERR_EN
      do_write(32'h12, 32'hDEAD, 1, 1'b0, 2, 32'h12345678);
`else
      do_write(32'h12, 32'hDEAD, 1, 1'b0, 0, 32'hDEAD);
`endif

      // Read and write in parallel
      fork
         do_read(32'd5, 32'd0, 2, 32'h9, 32'hAA, 0);
         do_write(32'd4, 32'h55, 1, 1'b0, 0, 32'h55);
      join

      // Reset while a write response is pending
      M_awvalid = 1'b1;
      M_Waddr   = 32'd1;
      tick();
      M_awvalid = 1'b0;
      M_wvalid  = 1'b1;
      M_Wdata   = 32'h77;
      tick();
      M_wvalid  = 1'b0;
      chk("wresp_pending", 32'(S_bvalid), 1);
      #2 PRESETn = 1'b0;
      #1;
      chk("midrst_bvalid", 32'(S_bvalid), 0);
      chk("midrst_wr_count", 32'(wr_count), 0);
      chk("midrst_last_result", last_result, 0);
      chk("midrst_awready", 32'(S_awready), 0);
      chk("midrst_arready", 32'(S_arready), 0);
      exp_count = 8'd0;
      @(negedge PCLK);
      #1 PRESETn = 1'b1;
      #1 chk("midrst_awready_pre", 32'(S_awready), 0);
      tick();
      chk("midrst_awready_post", 32'(S_awready), 1);
      do_read(32'd3, 32'd0, 0, 0, 0, 0);

      // Load colliding with the read handshake returns old data
      load(3, 16'h0007);
      ld_en   = 1'b1;
      ld_addr = 4'd3;
      ld_data = 16'h1234;
      do_read(32'd3, 32'd3, 0, 32'h7, 32'h7, 0);
      do_read(32'd3, 32'd5, 0, 32'h1234, 0, 0);

      // 256 writes wrap the counter
      for (int i = 0; i < 256; i++) begin
         do_write(32'(i % 16), 32'(i), 0, 1'b0, 0, 32'(i));
      end
      chk("wr_count_wrap", 32'(wr_count), 0);

      for (int i = 0; i < 20 && (rq.size() != 0 || wq.size() != 0); i++) tick();
      chk("rq_drained", 32'(rq.size()), 0);
      chk("wq_drained", 32'(wq.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
